clk_div_ctrl: RTL

Run-time controller for the divided-clock generator. It holds the current divide ratio, starts and stops the divided clock only on period boundaries, and accepts new ratios through a valid/ready handshake. A new ratio takes effect at the next period wrap, so `out_clk` never has a truncated or glitched phase. It sits between the system clock domain logic (control/CSR side) and every consumer of the low-rate clock or its period tick.

---
 rtl/clk_div_ctrl.sv | 68 ++++++
 1 files changed

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: run-time divide-ratio controller; starts, stops and switches ratio only on period wraps
module clk_div_ctrl #(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             out_clk,
  output logic             tick,
  output logic             busy,
  output logic [CNT_W-1:0] cur_div
);
  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt, div_q, pend_div, half;
  logic pend_valid, wrap, xfer, bad;
  assign half      = div_q >> 1;
  assign wrap      = (state != IDLE) && (cnt == div_q - 1'b1);
  assign xfer      = cfg_valid && !pend_valid;
  assign bad       = cfg_div < CNT_W'(2);
  assign cfg_ready = !pend_valid;
  assign busy      = state != IDLE;
  assign cur_div   = div_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      div_q      <= CNT_W'(DEFAULT_DIV);
      pend_div   <= '0;
      pend_valid <= 1'b0;
      out_clk    <= 1'b0;
      tick       <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      tick    <= wrap;
      cfg_err <= xfer && bad;
      if (state == IDLE) begin
        cnt     <= '0;
        out_clk <= 1'b0;
        if (en) state <= RUN;
      end else begin
        out_clk <= cnt < half;
        cnt     <= wrap ? '0 : cnt + 1'b1;
        if (state == RUN) begin
          if (!en) state <= STOP;
        end else
          state <= en ? RUN : wrap ? IDLE : STOP;
      end
      // pend_valid is still 0 on an acceptance edge, so a ratio taken at a wrap waits for the next one
      if (wrap && pend_valid) begin
        div_q      <= pend_div;
        pend_valid <= 1'b0;
      end
      if (xfer && !bad) begin
        if (state == IDLE) div_q <= cfg_div;
        else begin
          pend_div   <= cfg_div;
          pend_valid <= 1'b1;
        end
      end
    end
  end
endmodule
